// File: rtl/dma_cpu_programmer.sv
// rtl/dma_cpu_programmer.sv - host-request to 8237-style DMA register bus cycle sequencer
// Build option: DMA_PROG_FF_CLEAR_EN prefixes every wide access with a byte-pointer flip-flop clear
module dma_cpu_programmer #(
    parameter int DATAWIDTH     = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 HLDA,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic                 req_wide,
    input  logic [3:0]           req_reg,
    input  logic [15:0]          req_data,
    output logic                 CS_N,
    output logic                 IOR_N,
    output logic                 IOW_N,
    output logic [3:0]           A,
    output logic [DATAWIDTH-1:0] DB_OUT,
    output logic                 DB_OE,
    input  logic [DATAWIDTH-1:0] DB_IN,
    output logic                 rsp_valid,
    output logic [15:0]          rsp_data,
    output logic                 busy
);

`ifdef DMA_PROG_FF_CLEAR_EN
    localparam logic [1:0] CLR_CYCLES = 2'd1;
`else
    localparam logic [1:0] CLR_CYCLES = 2'd0;
`endif
    localparam logic [3:0] FF_CLEAR_ADDR = 4'b1100;
    localparam logic [3:0] STROBE_RELOAD = 4'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUS = 3'd1,
        SETUP    = 3'd2,
        STROBE   = 3'd3,
        RECOVER  = 3'd4,
        DONE     = 3'd5
    } stateT;

    stateT state;
    stateT nextState;

    logic                 curWrite;
    logic                 curWide;
    logic [3:0]           curReg;
    logic [15:0]          curData;
    logic [1:0]           cycIdx;
    logic [3:0]           strobeCnt;
    logic                 cycWrite;
    logic                 cycHi;
    logic [3:0]           addrReg;
    logic [DATAWIDTH-1:0] dbOutReg;
    logic [7:0]           rdLo;
    logic [7:0]           rdHi;
    logic [15:0]          rspDataReg;

    logic                 accept;
    logic                 lastCyc;
    logic                 strobeDone;
    logic                 srcWrite;
    logic                 srcWide;
    logic [3:0]           srcReg;
    logic [15:0]          srcData;
    logic [1:0]           loadIdx;
    logic                 loadClr;
    logic                 loadHi;
    logic                 loadWrite;
    logic [3:0]           loadAddr;
    logic [7:0]           loadByte;

    assign accept     = req_valid & req_ready;
    assign strobeDone = (strobeCnt == 4'd0);
    assign lastCyc    = curWide ? (cycIdx == CLR_CYCLES + 2'd1) : 1'b1;

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (accept) nextState = SETUP;
            WAIT_BUS: if (!HLDA) nextState = SETUP;
            SETUP:    nextState = STROBE;
            STROBE:   if (strobeDone) nextState = RECOVER;
            RECOVER: begin
                // bus ownership is only re-checked between byte cycles, never inside one
                if (lastCyc) begin
                    nextState = DONE;
                end else if (HLDA) begin
                    nextState = WAIT_BUS;
                end else begin
                    nextState = SETUP;
                end
            end
            DONE:     nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = RESET_N && (state == IDLE) && !HLDA;
        busy      = (state != IDLE);
        CS_N      = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        DB_OE     = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            SETUP: begin
                CS_N  = 1'b0;
                DB_OE = cycWrite;
            end
            STROBE: begin
                CS_N  = 1'b0;
                DB_OE = cycWrite;
                IOW_N = !cycWrite;
                IOR_N = cycWrite;
            end
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Byte-cycle descriptor for the next SETUP; in IDLE it comes straight from the request
    always_comb begin
        srcWrite = curWrite;
        srcWide  = curWide;
        srcReg   = curReg;
        srcData  = curData;
        loadIdx  = cycIdx;
        if (state == IDLE) begin
            srcWrite = req_write;
            srcWide  = req_wide;
            srcReg   = req_reg;
            srcData  = req_data;
            loadIdx  = 2'd0;
        end else if (state == RECOVER) begin
            loadIdx = cycIdx + 2'd1;
        end
        loadClr   = srcWide && (CLR_CYCLES != 2'd0) && (loadIdx == 2'd0);
        loadHi    = srcWide && (loadIdx == CLR_CYCLES + 2'd1);
        loadWrite = srcWrite || loadClr;
        loadAddr  = loadClr ? FF_CLEAR_ADDR : srcReg;
        if (loadClr || !loadWrite) begin
            loadByte = 8'h00;
        end else begin
            loadByte = loadHi ? srcData[15:8] : srcData[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            curWrite   <= 1'b0;
            curWide    <= 1'b0;
            curReg     <= 4'd0;
            curData    <= 16'h0000;
            cycIdx     <= 2'd0;
            strobeCnt  <= 4'd0;
            cycWrite   <= 1'b0;
            cycHi      <= 1'b0;
            addrReg    <= 4'd0;
            dbOutReg   <= '0;
            rdLo       <= 8'h00;
            rdHi       <= 8'h00;
            rspDataReg <= 16'h0000;
        end else begin
            if (accept) begin
                curWrite <= req_write;
                curWide  <= req_wide;
                curReg   <= req_reg;
                curData  <= req_data;
                cycIdx   <= 2'd0;
            end
            if (state == RECOVER && !lastCyc) begin
                cycIdx <= cycIdx + 2'd1;
            end
            if (nextState == SETUP) begin
                addrReg  <= loadAddr;
                dbOutReg <= DATAWIDTH'(loadByte);
                cycWrite <= loadWrite;
                cycHi    <= loadHi;
            end
            if (state == SETUP) begin
                strobeCnt <= STROBE_RELOAD;
            end else if (state == STROBE && !strobeDone) begin
                strobeCnt <= strobeCnt - 4'd1;
            end
            if (state == STROBE && strobeDone && !cycWrite) begin
                if (cycHi) begin
                    rdHi <= 8'(DB_IN);
                end else begin
                    rdLo <= 8'(DB_IN);
                end
            end
            if (nextState == DONE) begin
                if (curWrite) begin
                    rspDataReg <= 16'h0000;
                end else if (curWide) begin
                    rspDataReg <= {rdHi, rdLo};
                end else begin
                    rspDataReg <= {8'h00, rdLo};
                end
            end
        end
    end

    assign A        = addrReg;
    assign DB_OUT   = dbOutReg;
    assign rsp_data = rspDataReg;

endmodule

// File: tb/tb_dma_cpu_programmer.sv
// tb/tb_dma_cpu_programmer.sv - randomized bench for dma_cpu_programmer at strobe widths 2, 1 and 15
module tb_dma_cpu_programmer;

`ifdef DMA_PROG_FF_CLEAR_EN
    localparam int FFCLR = 1;
`else
    localparam int FFCLR = 0;
`endif

    logic clk;
    int   nTests = 0;
    int   nFail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int p, input logic [7:0] sd);
        return 8'(p * 29) ^ sd;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 15;

        logic        resetN, hlda, reqValid, reqReady, reqWrite, reqWide;
        logic [3:0]  reqReg;
        logic [15:0] reqData;
        logic        csN, iorN, iowN, dbOe, rspValid, busy;
        logic [3:0]  a;
        logic [7:0]  dbOut;
        logic [7:0]  dbIn;
        logic [15:0] rspData;
        logic        finished = 1'b0;
        logic [7:0]  seed = 8'h00;
        int          pulseCnt = 0;
        int          stray = 0;
        logic [3:0]  pA [512];
        logic [7:0]  pD [512];
        int          pStb [512];
        int          pLen [512];
        logic [3:0]  pFlags [512];

        dma_cpu_programmer #(.DATAWIDTH(8), .STROBE_CYCLES(S)) dut (
            .CLK(clk), .RESET_N(resetN), .HLDA(hlda),
            .req_valid(reqValid), .req_ready(reqReady), .req_write(reqWrite),
            .req_wide(reqWide), .req_reg(reqReg), .req_data(reqData),
            .CS_N(csN), .IOR_N(iorN), .IOW_N(iowN), .A(a),
            .DB_OUT(dbOut), .DB_OE(dbOe), .DB_IN(dbIn),
            .rsp_valid(rspValid), .rsp_data(rspData), .busy(busy)
        );

        // Records each chip-select window and plays the device side of DB during reads
        initial begin : monitor
            logic       inWin, wOe, wStable, wR, wW;
            logic [3:0] wA;
            logic [7:0] wD;
            int         winLen, stbLen, slot;
            inWin = 1'b0; wOe = 1'b0; wStable = 1'b1; wR = 1'b0; wW = 1'b0;
            wA = 4'd0; wD = 8'd0; winLen = 0; stbLen = 0; dbIn = 8'h00;
            forever begin
                @(negedge clk);
                if (csN === 1'b0) begin
                    if (!inWin) begin
                        inWin = 1'b1; winLen = 0; stbLen = 0; wA = a; wD = dbOut;
                        wOe = dbOe; wStable = 1'b1; wR = 1'b0; wW = 1'b0;
                    end else if (a !== wA || dbOut !== wD || dbOe !== wOe) begin
                        wStable = 1'b0;
                    end
                    winLen++;
                    if (iorN === 1'b0) begin
                        dbIn = (stbLen == S - 1) ? pat(pulseCnt, seed) : ~pat(pulseCnt, seed);
                        wR = 1'b1;
                        stbLen++;
                    end else begin
                        dbIn = 8'($urandom);
                    end
                    if (iowN === 1'b0) begin
                        wW = 1'b1;
                        stbLen++;
                    end
                end else begin
                    dbIn = 8'($urandom);
                    if (iorN !== 1'b1 || iowN !== 1'b1 || dbOe !== 1'b0) stray++;
                    if (inWin) begin
                        slot = pulseCnt % 512;
                        pA[slot] = wA; pD[slot] = wD; pStb[slot] = stbLen; pLen[slot] = winLen;
                        pFlags[slot] = {wW, wR, wOe, wStable};
                        pulseCnt++;
                        inWin = 1'b0;
                    end
                end
            end
        end

        task automatic runTxn(input logic w, input logic wd, input logic [3:0] rg,
                              input logic [15:0] dt, input int hs, input int hl);
            int          n, clr, k, start, expWait, expLat, gotLat, slot;
            logic [15:0] expRsp, gotRsp;
            logic [7:0]  lo, hi, expByte;
            logic [3:0]  expAddr;
            logic        got, isW;
            clr     = (wd && FFCLR != 0) ? 1 : 0;
            n       = wd ? 2 + clr : 1;
            start   = pulseCnt;
            lo      = pat(start + clr, seed);
            hi      = pat(start + clr + 1, seed);
            expRsp  = w ? 16'h0000 : (wd ? {hi, lo} : {8'h00, lo});
            expWait = (n > 1 && hs + hl >= S + 2) ? hs + hl - (S + 2) + 1 : 0;
            expLat  = 1 + n * (S + 2) + expWait;

            reqWrite = w; reqWide = wd; reqReg = rg; reqData = dt; reqValid = 1'b1;
            k = 0;
            while (!reqReady && k < 50) begin
                @(posedge clk); #1; k++;
            end
            checkVal($sformatf("s%0d ready", S), reqReady, 1'b1);
            @(posedge clk); #1;
            reqValid = 1'b0;
            reqWrite = 1'($urandom); reqWide = 1'($urandom);
            reqReg = 4'($urandom); reqData = 16'($urandom);
            checkVal($sformatf("s%0d busy", S), busy, 1'b1);

            k = 0; got = 1'b0; gotLat = 0; gotRsp = 16'hxxxx;
            while (1) begin
                hlda = (k >= hs && k < hs + hl);
                if (!got && rspValid) begin
                    got = 1'b1; gotLat = k + 1; gotRsp = rspData;
                end
                if ((got && k >= hs + hl) || k > 200) break;
                @(posedge clk); #1; k++;
            end
            hlda = 1'b0;
            checkVal($sformatf("s%0d lat w%0d wd%0d h%0d/%0d", S, w, wd, hs, hl), gotLat, expLat);
            checkVal($sformatf("s%0d rsp", S), gotRsp, expRsp);
            @(posedge clk); #1;
            checkVal($sformatf("s%0d idle", S), {rspValid, busy, reqReady}, 3'b001);
            checkVal($sformatf("s%0d hold", S), rspData, expRsp);
            checkVal($sformatf("s%0d ncyc", S), pulseCnt - start, n);
            for (int i = 0; i < n; i++) begin
                slot    = (start + i) % 512;
                isW     = (clr == 1 && i == 0) || w;
                expAddr = (clr == 1 && i == 0) ? 4'hC : rg;
                expByte = (clr == 1 && i == 0) ? 8'h00 : ((i - clr == 1) ? dt[15:8] : dt[7:0]);
                checkVal($sformatf("s%0d c%0d addr", S, i), pA[slot], expAddr);
                checkVal($sformatf("s%0d c%0d stb", S, i), pStb[slot], S);
                checkVal($sformatf("s%0d c%0d len", S, i), pLen[slot], S + 1);
                checkVal($sformatf("s%0d c%0d flags", S, i), pFlags[slot], {isW, !isW, isW, 1'b1});
                if (isW) checkVal($sformatf("s%0d c%0d data", S, i), pD[slot], expByte);
            end
        endtask

        task automatic resetMid();
            int   k;
            logic saw;
            seed = 8'($urandom);
            reqWrite = 1'b1; reqWide = 1'b1; reqReg = 4'h2; reqData = 16'h1234; reqValid = 1'b1;
            k = 0;
            while (!reqReady && k < 50) begin
                @(posedge clk); #1; k++;
            end
            @(posedge clk); #1;
            reqValid = 1'b0;
            k = 0;
            while (iowN !== 1'b0 && k < 50) begin
                @(posedge clk); #1; k++;
            end
            checkVal($sformatf("s%0d mid strobe", S), iowN, 1'b0);
            resetN = 1'b0;
            @(posedge clk); #1;
            checkVal($sformatf("s%0d mid rst pins", S), {csN, iorN, iowN, dbOe, rspValid, busy, reqReady}, 7'b1110000);
            resetN = 1'b1;
            #1;
            checkVal($sformatf("s%0d mid ready", S), reqReady, 1'b1);
            saw = 1'b0;
            for (int i = 0; i < 2 * S + 6; i++) begin
                @(posedge clk); #1;
                if (rspValid || csN !== 1'b1) saw = 1'b1;
            end
            checkVal($sformatf("s%0d mid quiet", S), saw, 1'b0);
            checkVal($sformatf("s%0d mid rsp", S), rspData, 16'h0000);
        endtask

        initial begin : drive
            logic        w, wd;
            logic [3:0]  rg;
            logic [15:0] dt;
            int          hs, hl;
            resetN = 1'b0; hlda = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqWide = 1'b0;
            reqReg = 4'd0; reqData = 16'h0000;
            repeat (2) @(posedge clk);
            #1;
            checkVal($sformatf("s%0d rst strobes", S), {csN, iorN, iowN, dbOe}, 4'b1110);
            checkVal($sformatf("s%0d rst a", S), a, 4'd0);
            checkVal($sformatf("s%0d rst db", S), dbOut, 8'h00);
            checkVal($sformatf("s%0d rst rsp", S), {rspValid, rspData}, 17'd0);
            checkVal($sformatf("s%0d rst busy", S), busy, 1'b0);
            checkVal($sformatf("s%0d rst ready", S), reqReady, 1'b0);
            resetN = 1'b1; hlda = 1'b1;
            #1;
            checkVal($sformatf("s%0d hlda ready", S), reqReady, 1'b0);
            hlda = 1'b0;
            @(posedge clk); #1;
            for (int t = 0; t < 20; t++) begin
                w  = 1'($urandom); wd = 1'($urandom); rg = 4'($urandom); dt = 16'($urandom);
                hs = int'($urandom_range(0, S + 1));
                hl = ($urandom % 3 == 0) ? int'($urandom_range(1, 6)) : 0;
                if (t == 0) begin w = 1'b1; wd = 1'b0; rg = 4'b1000; dt = 16'h0044; hl = 0; end
                if (t == 1) begin w = 1'b1; wd = 1'b1; rg = 4'b0010; dt = 16'h1234; hl = 0; end
                if (t == 2) begin w = 1'b0; wd = 1'b1; rg = 4'b0001; hl = 0; end
                if (t == 3) begin w = 1'b0; wd = 1'b0; rg = 4'b0111; hl = 0; end
                if (t == 4) begin w = 1'b1; wd = 1'b1; hs = S + 1; hl = 6; end
                if (t == 12) resetMid();
                seed = 8'($urandom);
                runTxn(w, wd, rg, dt, hs, hl);
            end
            checkVal($sformatf("s%0d stray", S), stray, 0);
            finished = 1'b1;
        end
    end

    initial begin : master
        int k;
        k = 0;
        while (!(g_cfg[0].finished && g_cfg[1].finished && g_cfg[2].finished) && k < 60000) begin
            @(posedge clk);
            k++;
        end
        checkVal("all_done", {g_cfg[0].finished, g_cfg[1].finished, g_cfg[2].finished}, 3'b111);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
